// File: rtl/alu_exec_if.sv
// alu_exec_if: dispatch port from the reservation station plus the ALU side of the CDB.
interface alu_exec_if #(
  parameter int OPERATOR_WIDTH = 6,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROB_WIDTH      = 4
);
  logic                      in_rdy;
  logic                      in_clear;
  logic                      out_capacity_full;
  logic                      in_rs_enable;
  logic [OPERATOR_WIDTH-1:0] in_rs_type;
  logic [ADDRESS_WIDTH-1:0]  in_rs_pc;
  logic [DATA_WIDTH-1:0]     in_rs_imm;
  logic [DATA_WIDTH-1:0]     in_rs_left_oprand;
  logic [DATA_WIDTH-1:0]     in_rs_right_oprand;
  logic [ROB_WIDTH-1:0]      in_rs_dest;
  logic                      out_broadcast_enable;
  logic [ROB_WIDTH-1:0]      out_broadcast_reorder;
  logic [DATA_WIDTH-1:0]     out_broadcast_result;
  logic                      out_broadcast_jump;
  logic [ADDRESS_WIDTH-1:0]  out_broadcast_target_pc;
  modport master (
    output in_rdy, in_clear, in_rs_enable, in_rs_type, in_rs_pc, in_rs_imm,
           in_rs_left_oprand, in_rs_right_oprand, in_rs_dest,
    input  out_capacity_full, out_broadcast_enable, out_broadcast_reorder,
           out_broadcast_result, out_broadcast_jump, out_broadcast_target_pc
  );
  modport slave (
    input  in_rdy, in_clear, in_rs_enable, in_rs_type, in_rs_pc, in_rs_imm,
           in_rs_left_oprand, in_rs_right_oprand, in_rs_dest,
    output out_capacity_full, out_broadcast_enable, out_broadcast_reorder,
           out_broadcast_result, out_broadcast_jump, out_broadcast_target_pc
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: RV32I integer/branch/jump execution unit with issue queue driving the ALU CDB port.
// Define ALU_SERIAL_SHIFT_EN to replace the barrel shifter with a one-bit-per-cycle shifter.
module alu_exec #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ROB_WIDTH   = 4
) (
  input logic       in_clk,
  input logic       in_rst,
  alu_exec_if.slave bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI
  } op_e;
  typedef enum logic {IDLE, SHIFT} state_e;
  typedef struct packed {
    op_e                  op;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [31:0]          lhs;
    logic [31:0]          rhs;
    logic [ROB_WIDTH-1:0] dest;
  } entry_t;
  entry_t               q_mem [QUEUE_DEPTH];
  entry_t               hd;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  state_e               state_q, state_d;
  logic                 en_q, en_d, jump_q, jump_d;
  logic [ROB_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]          res_q, res_d, tgt_q, tgt_d;
  logic                 live, pop, push, go_shift, is_br, lts, ltu, eq;
  logic [31:0]          opr, pc4, pc_imm, shl, shr, sha, alu_res, alu_tgt;
  logic                 alu_jump;
  logic [4:0]           shamt;
  assign live   = bus.in_rdy & ~bus.in_clear;
  assign hd     = q_mem[head_q];
  assign pop    = live & (state_q == IDLE) & (count_q != '0);
  assign push   = live & bus.in_rs_enable & ((count_q != CW'(QUEUE_DEPTH)) | pop);
  assign opr    = (hd.op >= OP_ADDI) ? hd.imm : hd.rhs;
  assign shamt  = opr[4:0];
  assign pc4    = hd.pc + 32'd4;
  assign pc_imm = hd.pc + hd.imm;
  assign lts    = $signed(hd.lhs) < $signed(opr);
  assign ltu    = hd.lhs < opr;
  assign eq     = hd.lhs == opr;
  assign is_br  = hd.op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
`ifdef ALU_SERIAL_SHIFT_EN
  // Only reached with shamt==0; nonzero shifts go through the SHIFT state.
  assign shl = hd.lhs;
  assign shr = hd.lhs;
  assign sha = hd.lhs;
  logic       is_shift;
  logic [31:0] sv_q, sv_d, step;
  logic [4:0]  sc_q, sc_d;
  logic [1:0]  sk_q, sk_d;
  logic [ROB_WIDTH-1:0] st_q, st_d;
  assign is_shift = hd.op inside {OP_SLL, OP_SRL, OP_SRA, OP_SLLI, OP_SRLI, OP_SRAI};
  assign go_shift = pop & is_shift & (shamt != 5'd0);
  assign step = (sk_q == 2'd0) ? {sv_q[30:0], 1'b0} :
                (sk_q == 2'd1) ? {1'b0, sv_q[31:1]} : {sv_q[31], sv_q[31:1]};
`else
  assign shl      = hd.lhs << shamt;
  assign shr      = hd.lhs >> shamt;
  assign sha      = 32'($signed(hd.lhs) >>> shamt);
  assign go_shift = 1'b0;
`endif
  always_comb begin
    alu_res  = '0;
    alu_jump = 1'b0;
    alu_tgt  = '0;
    case (hd.op)
      OP_LUI:           alu_res = hd.imm;
      OP_AUIPC:         alu_res = pc_imm;
      OP_JAL:           begin alu_res = pc4; alu_jump = 1'b1; alu_tgt = pc_imm; end
      OP_JALR:          begin alu_res = pc4; alu_jump = 1'b1; alu_tgt = (hd.lhs + hd.imm) & ~32'd1; end
      OP_BEQ:           alu_jump = eq;
      OP_BNE:           alu_jump = ~eq;
      OP_BLT:           alu_jump = lts;
      OP_BGE:           alu_jump = ~lts;
      OP_BLTU:          alu_jump = ltu;
      OP_BGEU:          alu_jump = ~ltu;
      OP_ADD, OP_ADDI:  alu_res = hd.lhs + opr;
      OP_SUB:           alu_res = hd.lhs - opr;
      OP_SLT, OP_SLTI:  alu_res = {31'd0, lts};
      OP_SLTU, OP_SLTIU: alu_res = {31'd0, ltu};
      OP_XOR, OP_XORI:  alu_res = hd.lhs ^ opr;
      OP_OR, OP_ORI:    alu_res = hd.lhs | opr;
      OP_AND, OP_ANDI:  alu_res = hd.lhs & opr;
      OP_SLL, OP_SLLI:  alu_res = shl;
      OP_SRL, OP_SRLI:  alu_res = shr;
      OP_SRA, OP_SRAI:  alu_res = sha;
      default:          ;
    endcase
    if (is_br) alu_tgt = alu_jump ? pc_imm : pc4;
  end
  always_comb begin
    head_d  = bus.in_clear ? '0 : head_q + PW'(pop);
    tail_d  = bus.in_clear ? '0 : tail_q + PW'(push);
    count_d = bus.in_clear ? '0 : count_q + CW'(push) - CW'(pop);
    state_d = state_q;
    en_d    = 1'b0;
    tag_d   = tag_q;
    res_d   = res_q;
    jump_d  = jump_q;
    tgt_d   = tgt_q;
`ifdef ALU_SERIAL_SHIFT_EN
    sv_d    = sv_q;
    sc_d    = sc_q;
    sk_d    = sk_q;
    st_d    = st_q;
`endif
    if (bus.in_clear) begin
      state_d = IDLE;
    end else if (pop && !go_shift) begin
      en_d   = 1'b1;
      tag_d  = hd.dest;
      res_d  = alu_res;
      jump_d = alu_jump;
      tgt_d  = alu_tgt;
    end
`ifdef ALU_SERIAL_SHIFT_EN
    else if (go_shift) begin
      state_d = SHIFT;
      sv_d    = hd.lhs;
      sc_d    = shamt;
      sk_d    = hd.op inside {OP_SLL, OP_SLLI} ? 2'd0 : hd.op inside {OP_SRL, OP_SRLI} ? 2'd1 : 2'd2;
      st_d    = hd.dest;
    end else if (state_q == SHIFT) begin
      sv_d = step;
      sc_d = sc_q - 5'd1;
      if (sc_q == 5'd1) begin
        state_d = IDLE;
        en_d    = 1'b1;
        tag_d   = st_q;
        res_d   = step;
        jump_d  = 1'b0;
        tgt_d   = '0;
      end
    end
`endif
  end
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      en_q    <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      jump_q  <= 1'b0;
      tgt_q   <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
      sv_q    <= '0;
      sc_q    <= '0;
      sk_q    <= '0;
      st_q    <= '0;
`endif
    end else if (bus.in_rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      en_q    <= en_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      jump_q  <= jump_d;
      tgt_q   <= tgt_d;
`ifdef ALU_SERIAL_SHIFT_EN
      sv_q    <= sv_d;
      sc_q    <= sc_d;
      sk_q    <= sk_d;
      st_q    <= st_d;
`endif
    end
  end
  always_ff @(posedge in_clk) begin
    if (push) q_mem[tail_q] <= '{op: op_e'(bus.in_rs_type), pc: bus.in_rs_pc, imm: bus.in_rs_imm,
                                 lhs: bus.in_rs_left_oprand, rhs: bus.in_rs_right_oprand,
                                 dest: bus.in_rs_dest};
  end
  // Threshold one below depth covers the entry the dispatcher already has in flight.
  assign bus.out_capacity_full       = count_q >= CW'(QUEUE_DEPTH - 1);
  assign bus.out_broadcast_enable    = en_q;
  assign bus.out_broadcast_reorder   = tag_q;
  assign bus.out_broadcast_result    = res_q;
  assign bus.out_broadcast_jump      = jump_q;
  assign bus.out_broadcast_target_pc = tgt_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec (expectations follow ALU_SERIAL_SHIFT_EN).
module tb_alu_exec;
  localparam logic [5:0] LUI = 0, AUIPC = 1, JAL = 2, JALR = 3, BLT = 6, BLTU = 8, BGEU = 9,
    ADD = 10, SUB = 11, SLL = 12, SLT = 13, SLTU = 14, XOR_ = 15, SRA = 17, OR_ = 18, AND_ = 19,
    SLTI = 21, SLTIU = 22, ANDI = 25, SRLI = 27, SRAI = 28;
  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc, imm, l, r, exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  alu_exec_if bus ();
  alu_exec #(.QUEUE_DEPTH(4), .ROB_WIDTH(4)) dut (.in_clk(clk), .in_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [5:0] op, input logic [31:0] pc, imm, l, r, input logic [3:0] dest);
    bus.in_rs_enable = 1'b1;
    bus.in_rs_type = op;
    bus.in_rs_pc = pc;
    bus.in_rs_imm = imm;
    bus.in_rs_left_oprand = l;
    bus.in_rs_right_oprand = r;
    bus.in_rs_dest = dest;
  endtask
  task automatic idle;
    bus.in_rs_enable = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.in_rdy = 1'b1;
    bus.in_clear = 1'b0;
    send(0, 0, 0, 0, 0, 0);
    idle();
    repeat (2) tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b0) begin n_fail++; $display("FAIL reset_en got %0b want 0", bus.out_broadcast_enable); end
    n_chk++; if (bus.out_broadcast_reorder !== 4'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", bus.out_broadcast_reorder); end
    n_chk++; if (bus.out_broadcast_result !== 32'd0) begin n_fail++; $display("FAIL reset_res got %h want 0", bus.out_broadcast_result); end
    n_chk++; if (bus.out_broadcast_jump !== 1'b0) begin n_fail++; $display("FAIL reset_jump got %0b want 0", bus.out_broadcast_jump); end
    n_chk++; if (bus.out_broadcast_target_pc !== 32'd0) begin n_fail++; $display("FAIL reset_tgt got %h want 0", bus.out_broadcast_target_pc); end
    n_chk++; if (bus.out_capacity_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", bus.out_capacity_full); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_addi;
    send(20, 0, 32'hFFFFFFF9, 32'd5, 0, 4'd3);
    tick();
    idle();
    n_chk++; if (bus.out_broadcast_enable !== 1'b0) begin n_fail++; $display("FAIL addi_early got en=%0b want 0", bus.out_broadcast_enable); end
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b1) begin n_fail++; $display("FAIL addi_en got %0b want 1", bus.out_broadcast_enable); end
    n_chk++; if (bus.out_broadcast_reorder !== 4'd3) begin n_fail++; $display("FAIL addi_tag got %0d want 3", bus.out_broadcast_reorder); end
    n_chk++; if (bus.out_broadcast_result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL addi_res got %h want fffffffe", bus.out_broadcast_result); end
    n_chk++; if (bus.out_broadcast_jump !== 1'b0) begin n_fail++; $display("FAIL addi_jump got %0b want 0", bus.out_broadcast_jump); end
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b0) begin n_fail++; $display("FAIL addi_pulse got en=%0b want 0", bus.out_broadcast_enable); end
    n_chk++; if (bus.out_broadcast_result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL addi_hold got %h want fffffffe", bus.out_broadcast_result); end
  endtask
  task automatic test_branch;
    send(BLT, 32'h100, 32'h20, 32'hFFFFFFFF, 32'd1, 4'd1);
    tick();
    send(BGEU, 32'h100, 32'h20, 32'hFFFFFFFF, 32'd1, 4'd2);
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b1 || bus.out_broadcast_reorder !== 4'd1) begin n_fail++; $display("FAIL blt_tag got en=%0b tag=%0d want 1/1", bus.out_broadcast_enable, bus.out_broadcast_reorder); end
    n_chk++; if (bus.out_broadcast_jump !== 1'b1 || bus.out_broadcast_target_pc !== 32'h120) begin n_fail++; $display("FAIL blt_jump got %0b/%h want 1/120", bus.out_broadcast_jump, bus.out_broadcast_target_pc); end
    n_chk++; if (bus.out_broadcast_result !== 32'd0) begin n_fail++; $display("FAIL blt_res got %h want 0", bus.out_broadcast_result); end
    send(BLTU, 32'h100, 32'h20, 32'hFFFFFFFF, 32'd1, 4'd3);
    tick();
    n_chk++; if (bus.out_broadcast_reorder !== 4'd2 || bus.out_broadcast_jump !== 1'b1 || bus.out_broadcast_target_pc !== 32'h120) begin n_fail++; $display("FAIL bgeu got tag=%0d jump=%0b tgt=%h want 2/1/120", bus.out_broadcast_reorder, bus.out_broadcast_jump, bus.out_broadcast_target_pc); end
    idle();
    tick();
    n_chk++; if (bus.out_broadcast_reorder !== 4'd3 || bus.out_broadcast_jump !== 1'b0 || bus.out_broadcast_target_pc !== 32'h104) begin n_fail++; $display("FAIL bltu got tag=%0d jump=%0b tgt=%h want 3/0/104", bus.out_broadcast_reorder, bus.out_broadcast_jump, bus.out_broadcast_target_pc); end
    tick();
  endtask
  task automatic test_jump;
    send(JALR, 32'h40, 32'd0, 32'h1003, 32'd0, 4'd5);
    tick();
    send(JAL, 32'h200, 32'hFFFFFFF8, 32'd0, 32'd0, 4'd6);
    tick();
    n_chk++; if (bus.out_broadcast_result !== 32'h44 || bus.out_broadcast_target_pc !== 32'h1002 || bus.out_broadcast_jump !== 1'b1 || bus.out_broadcast_reorder !== 4'd5) begin n_fail++; $display("FAIL jalr got res=%h tgt=%h jump=%0b tag=%0d want 44/1002/1/5", bus.out_broadcast_result, bus.out_broadcast_target_pc, bus.out_broadcast_jump, bus.out_broadcast_reorder); end
    idle();
    tick();
    n_chk++; if (bus.out_broadcast_result !== 32'h204 || bus.out_broadcast_target_pc !== 32'h1F8 || bus.out_broadcast_jump !== 1'b1 || bus.out_broadcast_reorder !== 4'd6) begin n_fail++; $display("FAIL jal got res=%h tgt=%h jump=%0b tag=%0d want 204/1f8/1/6", bus.out_broadcast_result, bus.out_broadcast_target_pc, bus.out_broadcast_jump, bus.out_broadcast_reorder); end
    tick();
  endtask
  task automatic test_alu_vectors;
    vec_t v[16] = '{
      '{ADD,   0, 0, 32'd7, 32'd8, 32'd15},
      '{SUB,   0, 0, 32'd3, 32'd5, 32'hFFFFFFFE},
      '{XOR_,  0, 0, 32'hF0F0, 32'hFF00, 32'h0FF0},
      '{OR_,   0, 0, 32'hF0F0, 32'hFF00, 32'hFFF0},
      '{AND_,  0, 0, 32'hF0F0, 32'hFF00, 32'hF000},
      '{SLT,   0, 0, 32'hFFFFFFFF, 32'd1, 32'd1},
      '{SLTU,  0, 0, 32'hFFFFFFFF, 32'd1, 32'd0},
      '{SLTI,  0, 32'hFFFFFFFD, 32'd5, 0, 32'd0},
      '{SLTIU, 0, 32'hFFFFFFFD, 32'd5, 0, 32'd1},
      '{SLL,   0, 0, 32'd1, 32'd33, 32'd2},
      '{SRLI,  0, 32'd31, 32'h80000000, 0, 32'd1},
      '{SRAI,  0, 32'd31, 32'h80000000, 0, 32'hFFFFFFFF},
      '{LUI,   0, 32'h12345000, 0, 0, 32'h12345000},
      '{AUIPC, 32'h1000, 32'h2000, 0, 0, 32'h3000},
      '{ANDI,  0, 32'hFFFFFFF0, 32'hFF, 0, 32'hF0},
      '{SRA,   0, 0, 32'h80000000, 32'd32, 32'h80000000}
    };
    for (int i = 0; i < 16; i++) begin
      int w = 0;
      send(v[i].op, v[i].pc, v[i].imm, v[i].l, v[i].r, 4'(i % 15 + 1));
      tick();
      idle();
      while (bus.out_broadcast_enable !== 1'b1 && w < 40) begin tick(); w++; end
      n_chk++;
      if (w == 40) begin n_fail++; $display("FAIL vec%0d_timeout no broadcast within 40 cycles", i); end
      else if (bus.out_broadcast_result !== v[i].exp || bus.out_broadcast_reorder !== 4'(i % 15 + 1)) begin
        n_fail++; $display("FAIL vec%0d got res=%h tag=%0d want %h/%0d", i, bus.out_broadcast_result, bus.out_broadcast_reorder, v[i].exp, i % 15 + 1);
      end
    end
    tick();
  endtask
  task automatic test_back_to_back;
    int sent = 0, got = 0, first = -1, last = -1;
    for (int k = 0; k < 40 && got < 6; k++) begin
      if (bus.out_broadcast_enable === 1'b1) begin
        n_chk++;
        if (bus.out_broadcast_reorder !== 4'(got + 1) || bus.out_broadcast_result !== 32'(got + 100)) begin
          n_fail++; $display("FAIL b2b_order got tag=%0d res=%0d want %0d/%0d", bus.out_broadcast_reorder, bus.out_broadcast_result, got + 1, got + 100);
        end
        if (first < 0) first = k;
        last = k;
        got++;
      end
      if (sent < 6 && bus.out_capacity_full !== 1'b1) begin
        send(ADD, 0, 0, 32'(sent), 32'd100, 4'(sent + 1));
        sent++;
      end else idle();
      tick();
    end
    idle();
    n_chk++; if (got !== 6 || sent !== 6) begin n_fail++; $display("FAIL b2b_count got %0d/%0d want 6/6", got, sent); end
    n_chk++; if (last - first !== 5) begin n_fail++; $display("FAIL b2b_rate got span %0d want 5", last - first); end
    tick();
  endtask
  task automatic test_clear;
    logic [3:0] tags[$];
    for (int k = 0; k < 15; k++) begin
      if (bus.out_broadcast_enable === 1'b1) tags.push_back(bus.out_broadcast_reorder);
      bus.in_clear = (k == 3);
      if (k <= 3) send(ADD, 0, 0, 32'd1, 32'd1, (k == 3) ? 4'd9 : 4'(k + 1));
      else idle();
      tick();
    end
    n_chk++; if (tags.size() !== 2) begin n_fail++; $display("FAIL clear_count got %0d broadcasts want 2", tags.size()); end
    else begin
      n_chk++; if (tags[0] !== 4'd1 || tags[1] !== 4'd2) begin n_fail++; $display("FAIL clear_tags got %0d,%0d want 1,2", tags[0], tags[1]); end
    end
    send(ADD, 0, 0, 32'd1, 32'd2, 4'd5);
    tick();
    idle();
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b1 || bus.out_broadcast_reorder !== 4'd5 || bus.out_broadcast_result !== 32'd3) begin n_fail++; $display("FAIL clear_after got en=%0b tag=%0d res=%0d want 1/5/3", bus.out_broadcast_enable, bus.out_broadcast_reorder, bus.out_broadcast_result); end
    tick();
  endtask
  task automatic test_shift;
    int cyc[$];
    logic [31:0] res[$];
    logic [3:0] tag[$];
`ifdef ALU_SERIAL_SHIFT_EN
    int exp0 = 6, exp1 = 7;
`else
    int exp0 = 2, exp1 = 3;
`endif
    for (int k = 0; k < 15; k++) begin
      if (bus.out_broadcast_enable === 1'b1) begin cyc.push_back(k); res.push_back(bus.out_broadcast_result); tag.push_back(bus.out_broadcast_reorder); end
      if (k == 0) send(SRA, 0, 0, 32'h80000000, 32'd4, 4'd7);
      else if (k == 1) send(ADD, 0, 0, 32'd1, 32'd1, 4'd8);
      else idle();
      tick();
    end
    n_chk++; if (cyc.size() !== 2) begin n_fail++; $display("FAIL shift_count got %0d broadcasts want 2", cyc.size()); end
    else begin
      n_chk++; if (cyc[0] !== exp0 || res[0] !== 32'hF8000000 || tag[0] !== 4'd7) begin n_fail++; $display("FAIL shift_sra got c+%0d res=%h tag=%0d want c+%0d/f8000000/7", cyc[0], res[0], tag[0], exp0); end
      n_chk++; if (cyc[1] !== exp1 || res[1] !== 32'd2 || tag[1] !== 4'd8) begin n_fail++; $display("FAIL shift_add got c+%0d res=%h tag=%0d want c+%0d/2/8", cyc[1], res[1], tag[1], exp1); end
    end
  endtask
  task automatic test_rdy_freeze;
    int extra = 0;
    send(ADD, 0, 0, 32'd10, 32'd20, 4'd4);
    tick();
    idle();
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b1 || bus.out_broadcast_reorder !== 4'd4) begin n_fail++; $display("FAIL freeze_pre got en=%0b tag=%0d want 1/4", bus.out_broadcast_enable, bus.out_broadcast_reorder); end
    bus.in_rdy = 1'b0;
    send(ADD, 0, 0, 32'd1, 32'd1, 4'd5);
    tick();
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b1 || bus.out_broadcast_reorder !== 4'd4 || bus.out_broadcast_result !== 32'd30) begin n_fail++; $display("FAIL freeze_hold got en=%0b tag=%0d res=%0d want 1/4/30", bus.out_broadcast_enable, bus.out_broadcast_reorder, bus.out_broadcast_result); end
    bus.in_rdy = 1'b1;
    idle();
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b0) begin n_fail++; $display("FAIL freeze_release got en=%0b want 0", bus.out_broadcast_enable); end
    for (int k = 0; k < 6; k++) begin
      if (bus.out_broadcast_enable === 1'b1) extra++;
      tick();
    end
    n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL freeze_nopush got %0d broadcasts want 0", extra); end
  endtask
  task automatic test_async_reset;
    send(ADD, 0, 0, 32'd2, 32'd3, 4'd6);
    tick();
    idle();
    tick();
    n_chk++; if (bus.out_broadcast_enable !== 1'b1 || bus.out_broadcast_result !== 32'd5) begin n_fail++; $display("FAIL arst_pre got en=%0b res=%0d want 1/5", bus.out_broadcast_enable, bus.out_broadcast_result); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.out_broadcast_enable !== 1'b0 || bus.out_broadcast_result !== 32'd0 || bus.out_broadcast_reorder !== 4'd0) begin n_fail++; $display("FAIL arst_clear got en=%0b res=%0d tag=%0d want 0/0/0", bus.out_broadcast_enable, bus.out_broadcast_result, bus.out_broadcast_reorder); end
    tick();
    rst = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jump();
    test_alu_vectors();
    test_back_to_back();
    test_clear();
    test_shift();
    test_rdy_freeze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
